// File: rtl/fir_pkg.sv
// Shared constants and sizing helpers for the FIR result collector slice.
package fir_pkg;

    localparam int SIZE_DEF = 8;
    localparam int Y_W      = 2 * SIZE_DEF;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int fill_w(input int n);
        return clog2(n + 1);
    endfunction

endpackage

// File: rtl/fir_result_collector_if.sv
// Result stream handshake leaving the FIR collector.
interface fir_result_collector_if
    import fir_pkg::*;
#(
    parameter int W = Y_W
) ();

    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy counter.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = Y_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [fill_w(DEPTH)-1:0] count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = fill_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves in the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fir_result_collector.sv
// Drain end of the systolic FIR chain: tags, warm-up drop, FIFO, credit.
// Optional drop counter port enabled by COLLECTOR_DROP_COUNT_EN.
module fir_result_collector
    import fir_pkg::*;
#(
    parameter int SIZE   = SIZE_DEF,
    parameter int TAPS   = 4,
    parameter int LAT    = TAPS,
    parameter int WARMUP = TAPS - 1,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*SIZE-1:0]        chain_y,
    fir_result_collector_if.master   res,
    output logic                     overflow,
    output logic [fill_w(DEPTH)-1:0] fill_level
`ifdef COLLECTOR_DROP_COUNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    localparam int IFW  = fill_w(LAT);
    localparam int WU_W = (WARMUP > 0) ? fill_w(WARMUP) : 1;

    logic [LAT-1:0]  tags;
    logic [LAT:0]    shifted;
    logic [IFW-1:0]  in_flight;
    logic [WU_W-1:0] wu_cnt;
    logic            exit_tag;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            drop;

    assign shifted  = {tags, in_valid};
    assign exit_tag = tags[LAT-1];
    // start abandons whatever is leaving the chain this cycle.
    assign push     = exit_tag && !start && (wu_cnt == '0);
    assign pop      = res.out_valid && res.out_ready;
    assign drop     = push && full && !pop;
    assign in_ready = (32'(fill_level) + 32'(in_flight)) < 32'(DEPTH);

    assign res.out_valid = !empty;

    fir_sync_fifo #(
        .WIDTH (2*SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (chain_y),
        .dout  (res.out_data),
        .full  (full),
        .empty (empty),
        .count (fill_level)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            tags      <= '0;
            in_flight <= '0;
            wu_cnt    <= WU_W'(WARMUP);
            overflow  <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (start) begin
                tags      <= LAT'(in_valid);
                in_flight <= IFW'(in_valid);
                wu_cnt    <= WU_W'(WARMUP);
            end else begin
                tags      <= shifted[LAT-1:0];
                in_flight <= in_flight + IFW'(in_valid) - IFW'(exit_tag);
                if (exit_tag && wu_cnt != '0) wu_cnt <= wu_cnt - WU_W'(1);
            end
        end
    end

`ifdef COLLECTOR_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_result_collector.sv
// Scoreboard bench for fir_result_collector (SIZE=8, TAPS=4, DEPTH=8).
module tb_fir_result_collector;
    import fir_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        overflow;
    logic [15:0] chain_y;
    logic [3:0]  fill_level;
`ifdef COLLECTOR_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int cyc = 0;
    int ybase = 0;
    int total = 0;
    int bad = 0;
    int first_vis = -1;
    int issue3 = 0;
    int acc = 0;
    logic [15:0] q[$];

    fir_result_collector_if #(.W(16)) res ();

    fir_result_collector #(
        .SIZE   (8),
        .TAPS   (4),
        .LAT    (LAT),
        .WARMUP (3),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .chain_y    (chain_y),
        .res        (res),
        .overflow   (overflow),
        .fill_level (fill_level)
`ifdef COLLECTOR_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign chain_y = 16'(cyc - ybase) + 16'h0010;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result a sample issued in cycle c will carry when it leaves the chain.
    function automatic logic [15:0] yexp(input int c);
        return 16'(c + LAT - ybase) + 16'h0010;
    endfunction

    task automatic drain(input string tag);
        res.out_ready = 1'b1;
        for (int i = 0; i < 40 && res.out_valid; i++) tick();
        res.out_ready = 1'b0;
        chk({tag, "_empty"}, 32'(res.out_valid), 0);
        chk({tag, "_sb_left"}, 32'(q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (res.out_valid && first_vis < 0) first_vis = cyc;
        if (res.out_valid && res.out_ready) begin
            if (q.size() == 0) chk("sb_extra", 32'(q.size()), 1);
            else chk("sb_data", 32'(res.out_data), 32'(q.pop_front()));
        end
    end

    initial begin
        res.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(res.out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_data", 32'(res.out_data), 0);

        // 1: warm-up and latency
        reset = 1'b1;
        ybase = cyc + LAT;
        first_vis = -1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            if (k >= 3) q.push_back(yexp(cyc));
            if (k == 3) issue3 = cyc;
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        chk("t1_first_vis", 32'(first_vis), 32'(issue3 + 5));
        chk("t1_fill", 32'(fill_level), 3);
        chk("t1_head", 32'(res.out_data), 32'h0013);
        drain("t1");

        // 2: credit
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ybase = cyc + LAT;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid = in_ready;
            if (in_ready) begin
                if (acc >= 3) q.push_back(yexp(cyc));
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("t2_accepted", 32'(acc), 11);
        chk("t2_ovf", 32'(overflow), 0);
        chk("t2_fill", 32'(fill_level), 8);
        chk("t2_ready", 32'(in_ready), 0);

        // 4: push and pop on a full FIFO in the same edge
        in_valid = 1'b1;
        q.push_back(yexp(cyc));
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        res.out_ready = 1'b1;
        tick();
        res.out_ready = 1'b0;
        tick();
        chk("t4_fill", 32'(fill_level), 8);
        chk("t4_ovf", 32'(overflow), 0);

        // 3: overflow on a forced sample
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT + 1) tick();
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_fill", 32'(fill_level), 8);
`ifdef COLLECTOR_DROP_COUNT_EN
        chk("t3_drops", 32'(drop_count), 1);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t3_sticky", 32'(overflow), 1);

        // 5: start abandons in-flight results
        res.out_ready = 1'b1;
        repeat (2) tick();
        res.out_ready = 1'b0;
        chk("t5_fill6", 32'(fill_level), 6);
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("t5_ready_lo", 32'(in_ready), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_ready_hi", 32'(in_ready), 1);
        repeat (LAT + 1) tick();
        chk("t5_no_land", 32'(fill_level), 6);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid = in_ready && (acc < 4);
            if (in_valid) begin
                if (acc >= 3) q.push_back(yexp(cyc));
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("t5_fill7", 32'(fill_level), 7);
        drain("t5");

        // 6: reset mid-operation
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            q.push_back(yexp(cyc));
            tick();
        end
        in_valid = 1'b0;
        repeat (LAT + 2) tick();
        chk("t6_fill5", 32'(fill_level), 5);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        q.delete();
        chk("t6_valid", 32'(res.out_valid), 0);
        chk("t6_fill", 32'(fill_level), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_ready", 32'(in_ready), 1);
`ifdef COLLECTOR_DROP_COUNT_EN
        chk("t6_drops", 32'(drop_count), 0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_result_collector.md
Name: fir_result_collector

Overview:
Drain end of the systolic FIR pe chain.
- Tracks which chain outputs carry real results. The pe chain has no valid signal.
- Discards pipeline warm-up partial sums.
- Buffers accumulated y words in a FIFO and presents them on a valid/ready interface.
- Returns credit (in_ready) to the sample feeder. The chain cannot stall, so credit is the only backpressure.

Parameters:
SIZE, 8, sample/coeff width; y width is 2*SIZE (matches pe).
TAPS, 4, number of pe stages in the chain.
LAT, TAPS, cycles from in_valid at chain head to the matching result on chain_y.
WARMUP, TAPS-1, results dropped after reset or start.
DEPTH, 8, FIFO entries, power of two, >= LAT.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  one-cycle pulse: begin new stream.
in_valid  in  1  feeder injected a sample into chain head this cycle.
in_ready  out  1  credit: feeder may inject this cycle.
chain_y  in  2*SIZE  out_y of last pe.
out_data  out  2*SIZE  FIFO head word.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts out_data.
overflow  out  1  sticky: a valid result was dropped, FIFO full.
fill_level  out  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (reset==0 at clk edge):
  - delay line, in_flight, FIFO pointers, fill_level, overflow, out_data all cleared to 0.
  - warm-up counter loaded to WARMUP.
  - Applies mid-operation; in-flight tags and FIFO contents are lost.
  - After reset: out_valid=0, in_ready=1.
- Tag delay line:
  - LAT-bit shift register; bit 0 loads in_valid each cycle.
  - Tag exits at bit LAT-1, i.e. exactly LAT cycles after in_valid.
  - In the exit cycle, chain_y is sampled as that sample's result.
- in_flight:
  - Count of set tags, updated incrementally (+in_valid, -exiting tag).
  - Never recomputed by popcount.
- Warm-up:
  - An exiting tag with warm-up counter >0 decrements the counter and is discarded.
  - Otherwise the tag generates a push.
- Credit:
  - in_ready = (fill_level + in_flight) < DEPTH, combinational.
  - Feeder must not assert in_valid when in_ready=0.
  - If it does anyway, the sample is still tagged; protection then falls to overflow.
- FIFO:
  - First-word-fall-through: out_data valid in the same cycle out_valid=1.
  - Pop when out_valid && out_ready.
- Push when full:
  - Push while full and no pop: word dropped, overflow set.
  - overflow clears only on reset; start does not clear it.
- Push and pop in the same cycle:
  - Both execute, occupancy unchanged.
  - Legal when full.
  - Legal when empty only as push-then-visible-next-cycle; no combinational bypass.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally; occupancy is held in a separate counter.
- start:
  - Clears all delay-line tags and in_flight; in-flight results are abandoned.
  - Reloads the warm-up counter to WARMUP.
  - FIFO contents are kept.
  - start with in_valid in the same cycle: that sample is the first tag of the new stream.
  - start in the same cycle as a tag exit: the exiting tag is discarded.
- Width: chain_y is stored unmodified, 2*SIZE bits, no truncation.

Optional Feature:
COLLECTOR_DROP_COUNT_EN
- Defined: adds output port drop_count [15:0], cleared by reset, incremented on each dropped push, saturating at 16'hFFFF. overflow is unchanged.
- Undefined: port and counter absent; only the sticky overflow flag.

Decomposition:
- Shared package fir_pkg holds:
  - SIZE default and the y width constant 2*SIZE;
  - clog2 function;
  - fill_level width helper.
- One sub-module: fir_sync_fifo.
  - Parameters WIDTH, DEPTH.
  - Provides push, pop, full, empty, count and FWFT head.
  - Shares clk and the active-low synchronous reset.
- Delay line, warm-up and credit logic stay in the top.

Test Plan (SIZE=8, TAPS=4, LAT=4, WARMUP=3, DEPTH=8):
1. Warm-up and latency: release reset, 6 consecutive in_valid; chain_y driven 16'h0010+n.
   -> first 3 exiting tags discarded; 3 words pushed.
   -> out_data 16'h0013 first visible 5 cycles after that tag's in_valid.
2. Credit: out_ready=0, in_valid held whenever in_ready=1.
   -> in_ready falls when fill_level + in_flight = 8; total accepted = 8 + 3 warm-up.
   -> overflow stays 0, fill_level ends at 8.
3. Overflow: force in_valid while in_ready=0 with FIFO full, out_ready=0.
   -> word dropped, overflow=1 sticky through start.
   -> with COLLECTOR_DROP_COUNT_EN, drop_count=1.
4. Full push+pop: FIFO full, tag exits with out_ready=1.
   -> fill_level stays 8, no overflow, FIFO order preserved.
5. start mid-stream: 2 tags in flight, pulse start.
   -> in_flight=0, those results never appear.
   -> next 3 results discarded, FIFO contents intact.
6. Reset mid-operation: fill_level=5, reset low 1 cycle.
   -> out_valid=0, fill_level=0, overflow=0, in_ready=1 on the next cycle.
